pam_demodu: RTL and testbench

PAM_DEMODU -- requirements
Module: pam_demodu

---
 rtl/pam_demodu.sv | 170 +++++++++++++++++
 tb/tb_pam_demodu.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pam_demodu.sv
// PAM-4 demodulator: slices aligned ADC samples into 2-bit symbols and packs
// them MSB-first into AXI-stream words, framing LENGTH_DATA words with tlast.
module pam_demodu #(
  parameter int DATA_WIDTH = 32,
  parameter int PAM_ORDER = 4,
  parameter int AD_CVER_WIDTH = 12,
  parameter int LENGTH_DATA = 32,
  parameter logic [AD_CVER_WIDTH-1:0] TH_LOW = 12'h400,
  parameter logic [AD_CVER_WIDTH-1:0] TH_MID = 12'h800,
  parameter logic [AD_CVER_WIDTH-1:0] TH_HIGH = 12'hC00
) (
  input  logic                       clk,
  input  logic                       arst,
  input  logic [AD_CVER_WIDTH-1:0]   syn_demodu_data,
  input  logic                       syn_demodu_valid,
  output logic                       syn_demodu_ready,
  output logic [DATA_WIDTH-1:0]      S_AXIS_tdata,
  output logic                       S_AXIS_tvalid,
  input  logic                       S_AXIS_tready,
  output logic                       S_AXIS_tlast,
  output logic [DATA_WIDTH/8-1:0]    S_AXIS_tkeep,
  output logic                       frame_done
);

  localparam int SYM_W  = $clog2(PAM_ORDER);
  localparam int SYMS   = DATA_WIDTH / SYM_W;
  localparam int ACC_W  = DATA_WIDTH - SYM_W;
  localparam int SC_W   = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int WC_W   = (LENGTH_DATA > 1) ? $clog2(LENGTH_DATA) : 1;
  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam logic [SC_W-1:0] SYM_LAST  = SC_W'(SYMS - 1);
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(LENGTH_DATA - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } state_e;

  // Equality with a threshold resolves to the upper symbol.
  function automatic logic [SYM_W-1:0] slice_sym(input logic [AD_CVER_WIDTH-1:0] s);
    logic [SYM_W-1:0] sym;
    if (s >= TH_HIGH) begin
      sym = 2'b11;
    end else if (s >= TH_MID) begin
      sym = 2'b10;
    end else if (s >= TH_LOW) begin
      sym = 2'b01;
    end else begin
      sym = 2'b00;
    end
    return sym;
  endfunction

  state_e              state_q, state_d;
  logic [SC_W-1:0]     sym_cnt_q, sym_cnt_d;
  logic [WC_W-1:0]     word_cnt_q, word_cnt_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic [KEEP_W-1:0]   tkeep_q, tkeep_d;

  logic                  accept_s;
  logic                  last_sym_s;
  logic                  load_s;
  logic                  out_fire_s;
  logic [DATA_WIDTH-1:0] word_s;

  // The final symbol is held off only while the output register cannot drain.
  assign last_sym_s       = (sym_cnt_q == SYM_LAST);
  assign syn_demodu_ready = !(last_sym_s && tvalid_q && !S_AXIS_tready);
  assign accept_s         = syn_demodu_valid && syn_demodu_ready;
  assign load_s           = accept_s && last_sym_s;
  assign out_fire_s       = tvalid_q && S_AXIS_tready;
  assign word_s           = {acc_q, slice_sym(syn_demodu_data)};

  assign S_AXIS_tdata  = tdata_q;
  assign S_AXIS_tvalid = tvalid_q;
  assign S_AXIS_tlast  = tlast_q;
  assign S_AXIS_tkeep  = tkeep_q;
  assign frame_done    = out_fire_s && tlast_q;

  always_comb begin
    sym_cnt_d  = sym_cnt_q;
    word_cnt_d = word_cnt_q;
    acc_d      = acc_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tkeep_d    = tkeep_q;

    if (accept_s) begin
      acc_d     = word_s[ACC_W-1:0];
      sym_cnt_d = last_sym_s ? '0 : sym_cnt_q + SC_W'(1);
    end else begin
      acc_d     = acc_q;
      sym_cnt_d = sym_cnt_q;
    end

    // A new word may replace one being accepted this cycle, keeping tvalid high.
    if (load_s) begin
      tdata_d    = word_s;
      tvalid_d   = 1'b1;
      tlast_d    = (word_cnt_q == WORD_LAST);
      tkeep_d    = {KEEP_W{1'b1}};
      word_cnt_d = (word_cnt_q == WORD_LAST) ? '0 : word_cnt_q + WC_W'(1);
    end else if (out_fire_s) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      tkeep_d  = '0;
    end else begin
      tvalid_d = tvalid_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_s && (word_cnt_q == WORD_LAST)) begin
          state_d = LAST;
        end else if (accept_s) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (load_s && (word_cnt_q == WORD_LAST)) begin
          state_d = LAST;
        end else begin
          state_d = RUN;
        end
      end
      LAST: begin
        // Samples of the next frame may already be accumulating here.
        if (out_fire_s && tlast_q) begin
          state_d = accept_s ? RUN : IDLE;
        end else begin
          state_d = LAST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      sym_cnt_q  <= '0;
      word_cnt_q <= '0;
      acc_q      <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tkeep_q    <= '0;
    end else begin
      state_q    <= state_d;
      sym_cnt_q  <= sym_cnt_d;
      word_cnt_q <= word_cnt_d;
      acc_q      <= acc_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tkeep_q    <= tkeep_d;
    end
  end

endmodule

// File: tb/tb_pam_demodu.sv
// Self-checking bench for pam_demodu: a word-level reference model built from
// the slicing and framing rules, driven with directed and random stimulus.
`timescale 1ns/1ps
module tb_pam_demodu;

  localparam int DW   = 32;
  localparam int AW   = 12;
  localparam int LD   = 32;
  localparam int SYMS = 16;

  logic          clk = 1'b0;
  logic          arst;
  logic [AW-1:0] syn_demodu_data;
  logic          syn_demodu_valid;
  logic          syn_demodu_ready;
  logic [DW-1:0] S_AXIS_tdata;
  logic          S_AXIS_tvalid;
  logic          S_AXIS_tready;
  logic          S_AXIS_tlast;
  logic [3:0]    S_AXIS_tkeep;
  logic          frame_done;

  pam_demodu dut (
    .clk              (clk),
    .arst             (arst),
    .syn_demodu_data  (syn_demodu_data),
    .syn_demodu_valid (syn_demodu_valid),
    .syn_demodu_ready (syn_demodu_ready),
    .S_AXIS_tdata     (S_AXIS_tdata),
    .S_AXIS_tvalid    (S_AXIS_tvalid),
    .S_AXIS_tready    (S_AXIS_tready),
    .S_AXIS_tlast     (S_AXIS_tlast),
    .S_AXIS_tkeep     (S_AXIS_tkeep),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] w;
    logic        l;
  } exp_t;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int          sym_count;
  logic [31:0] acc;
  int          word_idx;
  exp_t        exp_q[$];

  // observed DUT handshake statistics
  int words_out  = 0;
  int fd_seen    = 0;
  int tlast_seen = 0;

  function automatic logic [1:0] ref_slice(input int s);
    if (s >= 'hC00) return 2'd3;
    else if (s >= 'h800) return 2'd2;
    else if (s >= 'h400) return 2'd1;
    else return 2'd0;
  endfunction

  function automatic void model_reset();
    sym_count = 0;
    acc       = 32'd0;
    word_idx  = 0;
    exp_q.delete();
  endfunction

  function automatic logic [11:0] rand_sample();
    int unsigned pick;
    pick = $urandom_range(0, 9);
    case (pick)
      0: return 12'h3FF;
      1: return 12'h400;
      2: return 12'h7FF;
      3: return 12'h800;
      4: return 12'hBFF;
      5: return 12'hC00;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  // One clock of stimulus; compares the stream outputs with the model.
  task automatic stream_cycle(input logic v, input logic [11:0] d, input logic rdy,
                              output logic accepted);
    logic exp_ready;
    logic head_valid;
    logic fire;
    exp_t head;
    exp_t e;
    syn_demodu_valid = v;
    syn_demodu_data  = d;
    S_AXIS_tready    = rdy;
    #1;
    head_valid = (exp_q.size() != 0);
    head       = head_valid ? exp_q[0] : '0;
    exp_ready  = !((sym_count == SYMS - 1) && head_valid && !rdy);
    fire       = head_valid && rdy;

    n_vec++;
    if (syn_demodu_ready !== exp_ready) begin
      n_err++;
      $display("FAIL ready: got %b expected %b at %0t", syn_demodu_ready, exp_ready, $time);
    end
    n_vec++;
    if (S_AXIS_tvalid !== head_valid) begin
      n_err++;
      $display("FAIL tvalid: got %b expected %b at %0t", S_AXIS_tvalid, head_valid, $time);
    end
    n_vec++;
    if (S_AXIS_tkeep !== (head_valid ? 4'hF : 4'h0)) begin
      n_err++;
      $display("FAIL tkeep: got %h expected %h at %0t", S_AXIS_tkeep,
               head_valid ? 4'hF : 4'h0, $time);
    end
    if (head_valid) begin
      n_vec++;
      if (S_AXIS_tdata !== head.w || S_AXIS_tlast !== head.l) begin
        n_err++;
        $display("FAIL word: got %h/last=%b expected %h/last=%b at %0t",
                 S_AXIS_tdata, S_AXIS_tlast, head.w, head.l, $time);
      end
    end
    n_vec++;
    if (frame_done !== (fire && head.l)) begin
      n_err++;
      $display("FAIL frame_done: got %b expected %b at %0t", frame_done, fire && head.l, $time);
    end

    if (S_AXIS_tvalid === 1'b1 && rdy) begin
      words_out++;
      if (S_AXIS_tlast === 1'b1) tlast_seen++;
    end
    if (frame_done === 1'b1) fd_seen++;
    if (fire) void'(exp_q.pop_front());

    accepted = v && exp_ready;
    if (accepted) begin
      acc = acc * 4 + 32'(ref_slice(int'(d)));
      sym_count++;
      if (sym_count == SYMS) begin
        e.w = acc;
        e.l = (word_idx == LD - 1);
        exp_q.push_back(e);
        word_idx  = (word_idx + 1) % LD;
        sym_count = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    logic a;
    for (int i = 0; i < n; i++) stream_cycle(1'b0, 12'h000, 1'b1, a);
  endtask

  task automatic pulse_reset();
    syn_demodu_valid = 1'b0;
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    syn_demodu_valid = 1'b0;
    syn_demodu_data  = 12'h000;
    S_AXIS_tready    = 1'b0;
    arst = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (S_AXIS_tvalid !== 1'b0 || S_AXIS_tdata !== 32'h0 || S_AXIS_tlast !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: tvalid=%b tdata=%h tlast=%b expected 0/0/0",
               S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast);
    end
    n_vec++;
    if (S_AXIS_tkeep !== 4'h0 || frame_done !== 1'b0 || syn_demodu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ctl: tkeep=%h frame_done=%b ready=%b expected 0/0/1",
               S_AXIS_tkeep, frame_done, syn_demodu_ready);
    end
    arst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_pattern(input logic [11:0] p0, input logic [11:0] p1,
                              input logic [11:0] p2, input logic [11:0] p3,
                              input logic [31:0] want, input string name);
    logic [11:0] pat [4];
    logic a;
    pat = '{p0, p1, p2, p3};
    for (int i = 0; i < 16; i++) stream_cycle(1'b1, pat[i % 4], 1'b1, a);
    syn_demodu_valid = 1'b0;
    #1;
    n_vec++;
    if (S_AXIS_tvalid !== 1'b1 || S_AXIS_tdata !== want || S_AXIS_tkeep !== 4'hF) begin
      n_err++;
      $display("FAIL %s: tvalid=%b tdata=%h tkeep=%h expected 1/%h/f",
               name, S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tkeep, want);
    end
    drain(2);
  endtask

  task automatic test_backpressure();
    logic [11:0] s;
    logic a;
    int start_cnt;
    int taken;
    start_cnt = sym_count;
    taken = 0;
    s = rand_sample();
    for (int c = 0; c < 40; c++) begin
      stream_cycle(1'b1, s, 1'b0, a);
      if (a) begin
        taken++;
        s = rand_sample();
      end
    end
    n_vec++;
    if (taken !== 31 - start_cnt) begin
      n_err++;
      $display("FAIL stall_accepts: got %0d expected %0d", taken, 31 - start_cnt);
    end
    syn_demodu_valid = 1'b1;
    syn_demodu_data  = s;
    S_AXIS_tready    = 1'b0;
    #1;
    n_vec++;
    if (S_AXIS_tvalid !== 1'b1 || syn_demodu_ready !== 1'b0) begin
      n_err++;
      $display("FAIL stall_state: tvalid=%b ready=%b expected 1/0", S_AXIS_tvalid, syn_demodu_ready);
    end
    for (int c = 0; c < 40; c++) begin
      stream_cycle(1'b1, s, 1'b1, a);
      if (a) s = rand_sample();
    end
    drain(2);
  endtask

  task automatic test_full_frame();
    logic a;
    int w0, f0, t0;
    pulse_reset();
    w0 = words_out; f0 = fd_seen; t0 = tlast_seen;
    for (int i = 0; i < 512; i++) stream_cycle(1'b1, 12'hFFF, 1'b1, a);
    drain(3);
    n_vec++;
    if (words_out - w0 !== 32 || fd_seen - f0 !== 1 || tlast_seen - t0 !== 1) begin
      n_err++;
      $display("FAIL full_frame: words=%0d frame_done=%0d tlast=%0d expected 32/1/1",
               words_out - w0, fd_seen - f0, tlast_seen - t0);
    end
  endtask

  task automatic test_reset_mid();
    logic a;
    int w0, f0;
    for (int i = 0; i < 100; i++) stream_cycle(1'b1, rand_sample(), 1'b1, a);
    syn_demodu_valid = 1'b1;
    #2;
    arst = 1'b1;
    #1;
    n_vec++;
    if (S_AXIS_tvalid !== 1'b0 || S_AXIS_tdata !== 32'h0 || S_AXIS_tlast !== 1'b0 ||
        S_AXIS_tkeep !== 4'h0 || frame_done !== 1'b0 || syn_demodu_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: tvalid=%b tdata=%h tlast=%b tkeep=%h fd=%b ready=%b expected 0/0/0/0/0/1",
               S_AXIS_tvalid, S_AXIS_tdata, S_AXIS_tlast, S_AXIS_tkeep, frame_done, syn_demodu_ready);
    end
    syn_demodu_valid = 1'b0;
    @(negedge clk);
    arst = 1'b0;
    model_reset();
    w0 = words_out; f0 = fd_seen;
    for (int i = 0; i < 512; i++) stream_cycle(1'b1, rand_sample(), 1'b1, a);
    drain(3);
    n_vec++;
    if (words_out - w0 !== 32 || fd_seen - f0 !== 1) begin
      n_err++;
      $display("FAIL post_reset_frame: words=%0d frame_done=%0d expected 32/1",
               words_out - w0, fd_seen - f0);
    end
  endtask

  task automatic test_random();
    logic [11:0] s;
    logic a;
    logic v;
    logic r;
    int offered;
    int w0, f0, t0;
    int cyc;
    pulse_reset();
    w0 = words_out; f0 = fd_seen; t0 = tlast_seen;
    offered = 0;
    cyc = 0;
    s = rand_sample();
    while ((words_out - w0 < 96) && (cyc < 20000)) begin
      v = (offered < 1536) && ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 7);
      stream_cycle(v, s, r, a);
      if (a) begin
        offered++;
        s = rand_sample();
      end
      cyc++;
    end
    drain(2);
    n_vec++;
    if (words_out - w0 !== 96 || offered !== 1536) begin
      n_err++;
      $display("FAIL random_words: words=%0d samples=%0d expected 96/1536 (cycles %0d)",
               words_out - w0, offered, cyc);
    end
    n_vec++;
    if (fd_seen - f0 !== 3 || tlast_seen - t0 !== 3) begin
      n_err++;
      $display("FAIL random_frames: frame_done=%0d tlast=%0d expected 3/3",
               fd_seen - f0, tlast_seen - t0);
    end
  endtask

  initial begin
    arst             = 1'b1;
    syn_demodu_valid = 1'b0;
    syn_demodu_data  = 12'h000;
    S_AXIS_tready    = 1'b0;
    model_reset();
    test_reset();
    test_pattern(12'h000, 12'h500, 12'hA00, 12'hF00, 32'h1B1B1B1B, "slice_levels");
    test_pattern(12'h400, 12'h800, 12'hC00, 12'h3FF, 32'h6C6C6C6C, "slice_thresholds");
    test_backpressure();
    test_full_frame();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
